// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with debounce, encoding one key at a time onto the 5-bit timer key bus.
// Define KEYPAD_STROBE_EN to add a one-clock key_strobe pulse when a new key is accepted.
module keypad_scan_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key
`ifdef KEYPAD_STROBE_EN
  ,
  output logic       key_strobe
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [4:0]       KEY_NONE = 5'b11111;

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic [4:0]       code_q, code_d;
  logic [4:0]       key_q, key_d;
  logic             hit;
  logic [1:0]       hit_row;
  logic [4:0]       hit_code;
  logic             latched_low;

  // Unused positions (row 3, columns 0/2/3) map to KEY_NONE and are never accepted.
  function automatic logic [4:0] key_code(input logic [1:0] c, input logic [1:0] r);
    logic [4:0] code;
    code = KEY_NONE;
    case ({r, c})
      4'b00_00: code = 5'b00001;
      4'b00_01: code = 5'b00010;
      4'b00_10: code = 5'b00011;
      4'b00_11: code = 5'b11100;
      4'b01_00: code = 5'b00100;
      4'b01_01: code = 5'b00101;
      4'b01_10: code = 5'b00110;
      4'b01_11: code = 5'b11110;
      4'b10_00: code = 5'b00111;
      4'b10_01: code = 5'b01000;
      4'b10_10: code = 5'b01001;
      4'b10_11: code = 5'b11000;
      4'b11_01: code = 5'b00000;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Descending search so the lowest low row is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_row  = 2'd0;
    hit_code = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r] && (key_code(col_q, 2'(r)) != KEY_NONE)) begin
        hit      = 1'b1;
        hit_row  = 2'(r);
        hit_code = key_code(col_q, 2'(r));
      end
    end
  end

  assign latched_low = ~row_s2[row_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      row_q   <= 2'd0;
      code_q  <= KEY_NONE;
      key_q   <= KEY_NONE;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      code_q  <= code_d;
      key_q   <= key_d;
    end
  end

  // Counter clears on every state entry and the terminal count is the exit, so it never wraps.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    code_d  = code_q;
    key_d   = key_q;
    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hit) begin
            state_d = PRESS_DB;
            row_d   = hit_row;
            code_d  = hit_code;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (latched_low) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            key_d   = code_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!latched_low) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end
      end
      REL_DB: begin
        if (latched_low) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SCAN;
          key_d   = KEY_NONE;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col_n = ~(4'b0001 << col_q);
  assign key   = key_q;

`ifdef KEYPAD_STROBE_EN
  always_ff @(posedge clk) begin
    if (rst) key_strobe <= 1'b0;
    else     key_strobe <= (state_q == PRESS_DB) && (state_d == HELD);
  end
`endif

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: matrix model drives row_n from col_n and the set of pressed keys.
module tb_keypad_scan_encoder;

  localparam int         SCAN_DIV     = 4;
  localparam int         DEBOUNCE_CNT = 8;
  localparam logic [4:0] NONE  = 5'b11111;
  localparam logic [4:0] START = 5'b11100;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic       valid;
    logic [4:0] code;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      row_n;
  logic [3:0]      col_n;
  logic [4:0]      key;
`ifdef KEYPAD_STROBE_EN
  logic            key_strobe;
`endif
  logic [3:0][3:0] pressed = '0;
  logic [4:0]      exp_q[$];
  logic [4:0]      prev_key = NONE;
  logic [3:0]      exp_col;
  vec_t            vecs[16];
  int              n_checks = 0;
  int              n_errors = 0;

  always #5 clk = ~clk;

  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk  (clk),
    .rst  (rst),
    .row_n(row_n),
    .col_n(col_n),
    .key  (key)
`ifdef KEYPAD_STROBE_EN
    ,
    .key_strobe(key_strobe)
`endif
  );

  // A pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r] & ~col_n);
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input logic [4:0] want, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (key === want) break;
      step();
    end
    check(name, key, want);
  endtask

  // Returns just after the edge on which col_n first becomes pat.
  task automatic wait_col(input logic [3:0] pat, input int limit);
    for (int i = 0; i < limit && col_n === pat; i++) step();
    for (int i = 0; i < limit && col_n !== pat; i++) step();
    check("wait_col", {1'b0, col_n}, {1'b0, pat});
  endtask

  // Scoreboard: each transition of key onto a code consumes the oldest expected code.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (key !== prev_key && key !== NONE) begin
        check("code_to_code", prev_key, NONE);
        if (exp_q.size() == 0) check("unexpected_key", key, NONE);
        else check("scoreboard_key", key, exp_q.pop_front());
      end
`ifdef KEYPAD_STROBE_EN
      check("strobe", {4'b0000, key_strobe}, {4'b0000, (prev_key === NONE) && (key !== NONE)});
`endif
      prev_key = key;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd0, 2'd0, 1'b1, 5'b00001};
    vecs[1]  = '{2'd0, 2'd1, 1'b1, 5'b00010};
    vecs[2]  = '{2'd0, 2'd2, 1'b1, 5'b00011};
    vecs[3]  = '{2'd0, 2'd3, 1'b1, 5'b11100};
    vecs[4]  = '{2'd1, 2'd0, 1'b1, 5'b00100};
    vecs[5]  = '{2'd1, 2'd1, 1'b1, 5'b00101};
    vecs[6]  = '{2'd1, 2'd2, 1'b1, 5'b00110};
    vecs[7]  = '{2'd1, 2'd3, 1'b1, 5'b11110};
    vecs[8]  = '{2'd2, 2'd0, 1'b1, 5'b00111};
    vecs[9]  = '{2'd2, 2'd1, 1'b1, 5'b01000};
    vecs[10] = '{2'd2, 2'd2, 1'b1, 5'b01001};
    vecs[11] = '{2'd2, 2'd3, 1'b1, 5'b11000};
    vecs[12] = '{2'd3, 2'd0, 1'b0, 5'b11111};
    vecs[13] = '{2'd3, 2'd1, 1'b1, 5'b00000};
    vecs[14] = '{2'd3, 2'd2, 1'b0, 5'b11111};
    vecs[15] = '{2'd3, 2'd3, 1'b0, 5'b11111};

    // Reset, then idle scan: each column for SCAN_DIV clocks.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_col", {1'b0, col_n}, 5'b01110);
    check("reset_key", key, NONE);
    for (int k = 1; k < 16; k++) begin
      step();
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", {1'b0, col_n}, {1'b0, exp_col});
    end
    repeat (84) step();
    check("idle_key", key, NONE);

    // Digit 4 held from reset: eval at edge 4, key on edge 12.
    pressed[1][0] = 1'b1;
    exp_q.push_back(5'b00100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 11) check("press_lat_pre", key, NONE);
      if (k == 12) begin
        check("press_lat", key, 5'b00100);
        check("press_col_lock", {1'b0, col_n}, 5'b01110);
      end
    end
    pressed[1][0] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 10) check("rel_lat_pre", key, 5'b00100);
      if (k == 11) begin
        check("rel_lat", key, NONE);
        check("rel_next_col", {1'b0, col_n}, 5'b01101);
      end
    end

    // Start with bounce: low 3, high 1, then steady low.
    wait_col(4'b0111, 40);
    step();
    pressed[0][3] = 1'b1;
    repeat (3) step();
    pressed[0][3] = 1'b0;
    step();
    pressed[0][3] = 1'b1;
    repeat (2) step();
    check("bounce_abort_col", {1'b0, col_n}, 5'b01110);
    check("bounce_key", key, NONE);
    exp_q.push_back(START);
    wait_for(START, 60, "bounce_reacquire");
    pressed[0][3] = 1'b0;
    wait_for(NONE, 40, "start_release");

    // Timing and Start together: lowest row wins.
    pressed[0][3] = 1'b1;
    pressed[2][3] = 1'b1;
    exp_q.push_back(START);
    wait_for(START, 60, "multi_row");
    pressed = '0;
    wait_for(NONE, 40, "multi_release");

    pressed[3][0] = 1'b1;
    repeat (64) step();
    check("unused_ignored", key, NONE);
    pressed = '0;
    repeat (8) step();

    // Reset while digit 0 is held, then re-acquire.
    pressed[3][1] = 1'b1;
    exp_q.push_back(5'b00000);
    wait_for(5'b00000, 60, "digit0_held");
    rst = 1'b1;
    step();
    check("rst_mid_key", key, NONE);
    check("rst_mid_col", {1'b0, col_n}, 5'b01110);
    rst = 1'b0;
    exp_q.push_back(5'b00000);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) check("reacq_pre", key, NONE);
      if (k == 16) check("reacq", key, 5'b00000);
    end
    pressed = '0;
    wait_for(NONE, 40, "digit0_release");

    for (int i = 0; i < 16; i++) begin
      pressed = '0;
      pressed[vecs[i].row][vecs[i].col] = 1'b1;
      if (vecs[i].valid) begin
        exp_q.push_back(vecs[i].code);
        wait_for(vecs[i].code, 80, "table_press");
        pressed = '0;
        wait_for(NONE, 40, "table_release");
      end else begin
        repeat (48) step();
        check("table_unused", key, NONE);
        pressed = '0;
      end
      repeat (4) step();
    end

    check("scoreboard_drained", 5'(exp_q.size()), 5'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
